risc_intr_ctrl: RTL and testbench
=================================

Name: risc_intr_ctrl

Overview:
Parametrised vectored interrupt controller for the RISC core family. It replaces the single-line interrupt/return-register scheme with:
- N prioritised, maskable, edge-triggered sources
- a fixed vector table
- a hardware return stack that allows nested (preemptive) interrupts

It sits beside the datapath. The core samples irq_req/irq_vec at instruction boundaries and signals entry (irq_ack) and return (iret). Software configures it through the COM register bus.

Parameters:
N_IRQ, 8, number of interrupt sources (1..DATA_W); index 0 is highest priority.
DATA_W, 8, COM bus data width.
PC_W, 16, program counter width.
NEST_DEPTH, 4, return-stack entries (max nesting).
VEC_BASE, 16'h0010, vector address of source 0.
VEC_STRIDE, 4, address spacing between vectors.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
irq  in  N_IRQ  source lines, synchronous to clk, rising edge = request
cfg_we  in  1  register write strobe
cfg_addr  in  2  register select
cfg_wdata  in  DATA_W  write data
cfg_rdata  out  DATA_W  read data, combinational from cfg_addr
irq_req  out  1  interrupt to be taken
irq_vec  out  PC_W  target PC for current irq_req
irq_ack  in  1  core takes interrupt this cycle
ret_pc_in  in  PC_W  resume PC supplied with irq_ack
iret  in  1  core executes return-from-interrupt this cycle
ret_pc  out  PC_W  top-of-stack resume PC, valid while depth>0, else 0

Behaviour:
Reset: rst is synchronous, active-high; clock is clk. On reset, the following are all 0: MASK, PENDING, GIE, depth, err, irq_q, irq_req, and all stack entries. Active id = N_IRQ (none). cfg_rdata follows cfg_addr.

Register map:
- 0 MASK: RW; bit i=1 enables source i.
- 1 PENDING: read returns pending bits; write-1-to-clear.
- 2 CTRL: bit0 GIE, RW.
- 3 STATUS: RO. [3:0] active id (N_IRQ=none), [6:4] depth, [7] err (sticky; cleared by writing STATUS with bit7=1).
- Bits above N_IRQ read 0.

Edge detect:
- irq_q <= irq each cycle.
- PENDING[i] set when irq[i] & ~irq_q[i], regardless of MASK.
- Set and W1C on the same bit in the same cycle: set wins.

Selection (combinational):
- cand = lowest i with PENDING[i] & MASK[i].
- irq_req = GIE & cand exists & cand < active id & depth < NEST_DEPTH.
- irq_vec = VEC_BASE + cand*VEC_STRIDE, truncated to PC_W (wraps).
- irq_vec = 0 when irq_req = 0.

Entry (irq_ack=1 and irq_req=1), at next edge:
- push {ret_pc_in, active id}; depth+1.
- PENDING[cand] cleared.
- active id <= cand.
- irq_req drops the following cycle unless a higher-priority source is pending.
- irq_ack with irq_req=0 is ignored; no state change.

Return (iret=1, depth>0), at next edge:
- pop; active id <= saved id; depth-1.
- ret_pc shows the top entry before the pop (core loads PC from ret_pc in the iret cycle).
- iret with depth=0: ignored, err<=1.

Simultaneous irq_ack & iret: ack processed, iret ignored, err<=1.

Preemption: only strictly higher priority (smaller index) than the active id. Equal or lower priority stays pending until return.

Stack full (depth=NEST_DEPTH): irq_req held 0; pending bits retained.

GIE=0: requests are blocked but pending bits still accumulate.

Config write in the same cycle as ack/iret: both take effect. MASK/GIE affect irq_req from the next cycle.

Reset mid-nesting: stack and depth cleared immediately; the first post-reset cycle has irq_req=0.

Test Plan:
1. Reset, then MASK=0x04, GIE=1, pulse irq[2] -> next cycle PENDING=0x04, irq_req=1, irq_vec=0x0018. irq_ack with ret_pc_in=0x0123 -> STATUS=0x12, PENDING=0, irq_req=0, ret_pc=0x0123.
2. While serving id 2, pulse irq[5] then irq[0] (MASK=0x25) -> no req for 5; req with vec 0x0010 for 0. Ack with pc 0x0200 -> depth 2. iret returns ret_pc 0x0200 and active 2. Then req for 5 appears only after the second iret (active=none).
3. NEST_DEPTH=4: nest ids 7,6,5,4 -> depth 4. Pulse irq[0] -> irq_req stays 0 and PENDING bit0=1. One iret -> irq_req=1, vec 0x0010.
4. iret at depth 0 -> no state change, STATUS bit7=1. Write STATUS 0x80 -> bit7 cleared.
5. Same cycle: irq[3] rising edge and PENDING write 0x08 -> PENDING bit3 remains 1. GIE=0 with pending -> irq_req=0; write GIE=1 -> irq_req=1 next cycle.
6. Assert rst at depth 3 -> next cycle depth=0, active=none (0x08 in STATUS[3:0]), irq_req=0, ret_pc=0, MASK=0.

Source files
------------

// File: rtl/risc_intr_ctrl.sv
// Vectored, prioritised interrupt controller with a hardware return stack for
// nested interrupts. Configured over the COM register bus (MASK, PENDING, CTRL, STATUS).
module risc_intr_ctrl #(
    parameter int unsigned N_IRQ      = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PC_W       = 16,
    parameter int unsigned NEST_DEPTH = 4,
    parameter int unsigned VEC_BASE   = 32'h0010,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              irq_req,
    output logic [PC_W-1:0]   irq_vec,
    input  logic              irq_ack,
    input  logic [PC_W-1:0]   ret_pc_in,
    input  logic              iret,
    output logic [PC_W-1:0]   ret_pc
);

    localparam int unsigned ID_W  = $clog2(N_IRQ + 1);
    localparam int unsigned DEP_W = $clog2(NEST_DEPTH + 1);

    typedef enum logic [1:0] {
        REG_MASK    = 2'd0,
        REG_PENDING = 2'd1,
        REG_CTRL    = 2'd2,
        REG_STATUS  = 2'd3
    } reg_addr_e;

    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] irq_q;
    logic             gie_q, gie_d;
    logic             err_q, err_d;
    logic [DEP_W-1:0] depth_q, depth_d;
    logic [ID_W-1:0]  active_q, active_d;

    logic [PC_W-1:0]  stk_pc_q [NEST_DEPTH];
    logic [ID_W-1:0]  stk_id_q [NEST_DEPTH];

    logic [ID_W-1:0]  cand_id;
    logic             cand_vld;
    logic [N_IRQ-1:0] cand_oh;
    logic [PC_W-1:0]  top_pc;
    logic [ID_W-1:0]  top_id;
    logic             take, do_ret, ret_err;
    logic             wr_mask, wr_pend, wr_ctrl, wr_stat;

    // Candidate selection: lowest-index source that is both pending and enabled.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        cand_id  = ID_W'(N_IRQ);
        cand_vld = 1'b0;
        cand_oh  = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (pend_q[i] && mask_q[i]) begin
                cand_id  = ID_W'(i);
                cand_vld = 1'b1;
            end
        end
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (ID_W'(i) == cand_id) cand_oh[i] = cand_vld;
        end
    end

    always_comb begin
        top_pc = '0;
        top_id = ID_W'(N_IRQ);
        for (int i = 0; i < int'(NEST_DEPTH); i++) begin
            if (DEP_W'(i + 1) == depth_q) begin
                top_pc = stk_pc_q[i];
                top_id = stk_id_q[i];
            end
        end
    end

    assign irq_req = gie_q && cand_vld && (cand_id < active_q)
                     && (depth_q < DEP_W'(NEST_DEPTH));
    assign irq_vec = irq_req ? PC_W'(VEC_BASE) + PC_W'(cand_id) * PC_W'(VEC_STRIDE) : '0;
    assign ret_pc  = (depth_q != '0) ? top_pc : '0;

    // A taken ack wins over a concurrent iret, which is then flagged as an error.
    assign take    = irq_ack && irq_req;
    assign do_ret  = iret && (depth_q != '0) && !take;
    assign ret_err = iret && (take || (depth_q == '0));

    assign wr_mask = cfg_we && (cfg_addr == REG_MASK);
    assign wr_pend = cfg_we && (cfg_addr == REG_PENDING);
    assign wr_ctrl = cfg_we && (cfg_addr == REG_CTRL);
    assign wr_stat = cfg_we && (cfg_addr == REG_STATUS);

    always_comb begin
        mask_d   = wr_mask ? cfg_wdata[N_IRQ-1:0] : mask_q;
        gie_d    = wr_ctrl ? cfg_wdata[0] : gie_q;
        err_d    = (err_q && !(wr_stat && cfg_wdata[7])) || ret_err;
        // New edges are OR-ed in last so a set beats a same-cycle clear.
        pend_d   = (pend_q & ~(wr_pend ? cfg_wdata[N_IRQ-1:0] : '0)
                           & ~(take ? cand_oh : '0))
                   | (irq & ~irq_q);
        depth_d  = depth_q;
        active_d = active_q;
        if (take) begin
            depth_d  = depth_q + 1'b1;
            active_d = cand_id;
        end else if (do_ret) begin
            depth_d  = depth_q - 1'b1;
            active_d = top_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q   <= '0;
            pend_q   <= '0;
            irq_q    <= '0;
            gie_q    <= 1'b0;
            err_q    <= 1'b0;
            depth_q  <= '0;
            active_q <= ID_W'(N_IRQ);
            // NOTE: the return stack is small and must read as zero after reset, so it is cleared explicitly.
            for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                stk_pc_q[i] <= '0;
                stk_id_q[i] <= '0;
            end
        end else begin
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            irq_q    <= irq;
            gie_q    <= gie_d;
            err_q    <= err_d;
            depth_q  <= depth_d;
            active_q <= active_d;
            for (int i = 0; i < int'(NEST_DEPTH); i++) begin
                if (take && (DEP_W'(i) == depth_q)) begin
                    stk_pc_q[i] <= ret_pc_in;
                    stk_id_q[i] <= active_q;
                end
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_MASK:    cfg_rdata[N_IRQ-1:0] = mask_q;
            REG_PENDING: cfg_rdata[N_IRQ-1:0] = pend_q;
            REG_CTRL:    cfg_rdata[0] = gie_q;
            default: begin
                cfg_rdata[ID_W-1:0]  = active_q;
                cfg_rdata[4 +: DEP_W] = depth_q;
                cfg_rdata[7]          = err_q;
            end
        endcase
    end

endmodule

// File: tb/tb_risc_intr_ctrl.sv
// Scoreboard bench for risc_intr_ctrl: expectations are queued as stimulus is
// applied and compared against the DUT once the clock edge has taken effect.
module tb_risc_intr_ctrl;

    localparam int PERIOD = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_wdata;
    logic [7:0]  cfg_rdata;
    logic        irq_req;
    logic [15:0] irq_vec;
    logic        irq_ack;
    logic [15:0] ret_pc_in;
    logic        iret;
    logic [15:0] ret_pc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef enum logic [1:0] {K_REQ, K_VEC, K_RETPC, K_RD} kind_e;
    typedef struct {
        kind_e       kind;
        logic [1:0]  addr;
        string       tag;
        logic [15:0] exp;
    } exp_t;
    exp_t sb_q[$];

    risc_intr_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq       (irq),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .irq_req   (irq_req),
        .irq_vec   (irq_vec),
        .irq_ack   (irq_ack),
        .ret_pc_in (ret_pc_in),
        .iret      (iret),
        .ret_pc    (ret_pc)
    );

    always #(PERIOD / 2) clk = ~clk;

    initial begin
        #(PERIOD * 5000);
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    function automatic logic [15:0] vec_of(int id);
        return 16'h0010 + 16'(id * 4);
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(kind_e k, logic [1:0] a, string tag, logic [15:0] e);
        exp_t t;
        t.kind = k; t.addr = a; t.tag = tag; t.exp = e;
        sb_q.push_back(t);
    endtask

    // Compare every queued expectation against the current DUT outputs.
    task automatic drain();
        exp_t t;
        logic [15:0] obs;
        while (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            cfg_addr = t.addr;
            #1;
            case (t.kind)
                K_REQ:   obs = {15'd0, irq_req};
                K_VEC:   obs = irq_vec;
                K_RETPC: obs = ret_pc;
                default: obs = {8'd0, cfg_rdata};
            endcase
            check(t.tag, obs, t.exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(logic [1:0] a, logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic pulse(int id);
        irq[id] = 1'b1;
        tick();
        irq[id] = 1'b0;
    endtask

    task automatic ack(logic [15:0] pc);
        irq_ack = 1'b1; ret_pc_in = pc;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_iret();
        iret = 1'b1;
        tick();
        iret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        irq_ack = 1'b0; ret_pc_in = '0; iret = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        exp_push(K_REQ,   0, "rst_req",    16'h0);
        exp_push(K_VEC,   0, "rst_vec",    16'h0);
        exp_push(K_RETPC, 0, "rst_retpc",  16'h0);
        exp_push(K_RD,    0, "rst_mask",   16'h00);
        exp_push(K_RD,    1, "rst_pend",   16'h00);
        exp_push(K_RD,    3, "rst_status", 16'h08);
        drain();

        // Single interrupt entry
        cfg_write(0, 8'h04);
        cfg_write(2, 8'h01);
        pulse(2);
        exp_push(K_RD,  1, "t1_pend", 16'h04);
        exp_push(K_REQ, 0, "t1_req",  16'h1);
        exp_push(K_VEC, 0, "t1_vec",  vec_of(2));
        drain();
        ack(16'h0123);
        exp_push(K_RD,    3, "t1_status", 16'h12);
        exp_push(K_RD,    1, "t1_pend0",  16'h00);
        exp_push(K_REQ,   0, "t1_req0",   16'h0);
        exp_push(K_RETPC, 0, "t1_retpc",  16'h0123);
        drain();

        // Preemption by higher priority only
        cfg_write(0, 8'h25);
        pulse(5);
        exp_push(K_REQ, 0, "t2_lowpri_req", 16'h0);
        exp_push(K_RD,  1, "t2_pend5",      16'h20);
        drain();
        pulse(0);
        exp_push(K_REQ, 0, "t2_hipri_req", 16'h1);
        exp_push(K_VEC, 0, "t2_hipri_vec", vec_of(0));
        drain();
        ack(16'h0200);
        exp_push(K_RD,    3, "t2_status_d2", 16'h20);
        exp_push(K_RETPC, 0, "t2_retpc_d2",  16'h0200);
        exp_push(K_REQ,   0, "t2_req_d2",    16'h0);
        drain();
        iret = 1'b1;
        exp_push(K_RETPC, 0, "t2_retpc_in_iret", 16'h0200);
        drain();
        tick();
        iret = 1'b0;
        exp_push(K_RD,    3, "t2_status_d1", 16'h12);
        exp_push(K_RETPC, 0, "t2_retpc_d1",  16'h0123);
        exp_push(K_REQ,   0, "t2_req_d1",    16'h0);
        drain();
        do_iret();
        exp_push(K_RD,    3, "t2_status_d0", 16'h08);
        exp_push(K_REQ,   0, "t2_req5",      16'h1);
        exp_push(K_VEC,   0, "t2_vec5",      vec_of(5));
        exp_push(K_RETPC, 0, "t2_retpc_d0",  16'h0);
        drain();
        ack(16'h0300);
        do_iret();

        // Stack full
        cfg_write(0, 8'hF1);
        pulse(7);
        exp_push(K_VEC, 0, "t3_vec7", vec_of(7));
        drain();
        for (int id = 7; id >= 4; id--) begin
            if (id != 7) pulse(id);
            ack(16'h1000 + 16'(id));
        end
        exp_push(K_RD,  3, "t3_status_full", 16'h44);
        exp_push(K_REQ, 0, "t3_req_full",    16'h0);
        drain();
        pulse(0);
        exp_push(K_REQ, 0, "t3_req_blocked", 16'h0);
        exp_push(K_VEC, 0, "t3_vec_blocked", 16'h0);
        exp_push(K_RD,  1, "t3_pend_kept",   16'h01);
        drain();
        do_iret();
        exp_push(K_REQ, 0, "t3_req_after_pop", 16'h1);
        exp_push(K_VEC, 0, "t3_vec_after_pop", vec_of(0));
        exp_push(K_RD,  3, "t3_status_d3",     16'h35);
        exp_push(K_RETPC, 0, "t3_retpc_d3",    16'h1005);
        drain();

        // Reset while nested
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_push(K_RD,    3, "t6_status", 16'h08);
        exp_push(K_REQ,   0, "t6_req",    16'h0);
        exp_push(K_RETPC, 0, "t6_retpc",  16'h0);
        exp_push(K_RD,    0, "t6_mask",   16'h00);
        exp_push(K_RD,    1, "t6_pend",   16'h00);
        drain();

        // iret underflow and sticky error
        do_iret();
        exp_push(K_RD, 3, "t4_err_set", 16'h88);
        drain();
        cfg_write(3, 8'h80);
        exp_push(K_RD, 3, "t4_err_clr", 16'h08);
        drain();

        // Set beats W1C; GIE gating; ignored ack
        cfg_write(0, 8'h08);
        irq[3] = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'h08;
        tick();
        irq[3] = 1'b0; cfg_we = 1'b0;
        exp_push(K_RD,  1, "t5_set_wins", 16'h08);
        exp_push(K_REQ, 0, "t5_gie0_req", 16'h0);
        drain();
        ack(16'h0555);
        exp_push(K_RD, 3, "t5_ack_ignored", 16'h08);
        exp_push(K_RD, 1, "t5_pend_kept",   16'h08);
        drain();
        cfg_write(2, 8'h01);
        exp_push(K_REQ, 0, "t5_gie1_req", 16'h1);
        exp_push(K_VEC, 0, "t5_gie1_vec", vec_of(3));
        drain();

        // Simultaneous ack and iret
        irq_ack = 1'b1; ret_pc_in = 16'h0444; iret = 1'b1;
        tick();
        irq_ack = 1'b0; iret = 1'b0;
        exp_push(K_RD,    3, "t7_ack_iret_status", 16'h93);
        exp_push(K_RETPC, 0, "t7_ack_iret_retpc",  16'h0444);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
